lcd_timing: RTL and testbench

LCD_TIMING -- requirements
Module: lcd_timing

---
 rtl/video_types.sv | 17 +
 rtl/lcd_dot_counter.sv | 41 ++++
 rtl/lcd_timing.sv | 167 ++++++++++++++++
 tb/tb_lcd_timing.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_types.sv
// Shared LCD timing types and default (DMG-style) timing constants.
package video_types;

    typedef enum logic [1:0] {
        HBLANK = 2'd0,
        VBLANK = 2'd1,
        OAM    = 2'd2,
        XFER   = 2'd3
    } lcd_mode_t;

    localparam int DEF_DOTS_PER_LINE   = 456;
    localparam int DEF_LINES_PER_FRAME = 154;
    localparam int DEF_VISIBLE_LINES   = 144;
    localparam int DEF_OAM_DOTS        = 80;
    localparam int DEF_XFER_MIN_DOTS   = 172;

endpackage

// File: rtl/lcd_dot_counter.sv
// Dot / scanline counter. clr holds both counters at zero (LCD off or the
// restart cycle); otherwise one dot per clock, wrapping into the next line.
module lcd_dot_counter
    import video_types::*;
#(
    parameter int DOTS_PER_LINE   = DEF_DOTS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int DW              = $clog2(DOTS_PER_LINE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic [DW-1:0] dot,
    output logic [7:0]    ly,
    output logic          end_of_line,
    output logic          end_of_frame
);

    localparam logic [DW-1:0] DOT_LAST = DW'(DOTS_PER_LINE - 1);
    localparam logic [7:0]    LY_LAST  = 8'(LINES_PER_FRAME - 1);

    assign end_of_line  = !clr && (dot == DOT_LAST);
    assign end_of_frame = end_of_line && (ly == LY_LAST);

    // advance dot each clock, bump ly on line wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dot <= '0;
            ly  <= '0;
        end else if (clr) begin
            dot <= '0;
            ly  <= '0;
        end else if (end_of_line) begin
            dot <= '0;
            ly  <= end_of_frame ? 8'd0 : ly + 8'd1;
        end else begin
            dot <= dot + DW'(1);
        end
    end

endmodule

// File: rtl/lcd_timing.sv
// LCD scanline timing generator: mode sequencing, renderer handshake,
// VBlank interrupt and sticky overrun detection.
// Optional LY==LYC compare (coincidence / stat_irq) under macro
// LCD_TIMING_LYC_COMPARE_EN; without it those outputs are tied low.
module lcd_timing
    import video_types::*;
#(
    parameter int DOTS_PER_LINE   = DEF_DOTS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int VISIBLE_LINES   = DEF_VISIBLE_LINES,
    parameter int OAM_DOTS        = DEF_OAM_DOTS,
    parameter int XFER_MIN_DOTS   = DEF_XFER_MIN_DOTS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_en,
    input  logic       renderComplete,
    input  logic [7:0] lyc,
    output logic       drawline,
    output logic [7:0] ly,
    output logic [1:0] mode,
    output logic       vblank_irq,
    output logic       overrun,
    output logic       coincidence,
    output logic       stat_irq
);

    localparam int DW = $clog2(DOTS_PER_LINE);
    localparam logic [DW-1:0] OAM_LAST = DW'(OAM_DOTS - 1);
    localparam logic [DW-1:0] XMIN_M1  = DW'(XFER_MIN_DOTS - 1);
    localparam logic [7:0]    VIS      = 8'(VISIBLE_LINES);
    localparam logic [7:0]    VIS_LAST = 8'(VISIBLE_LINES - 1);

    lcd_mode_t     state, state_nxt;
    logic          en_q;
    logic          dl_q, dl_nxt;
    logic          vb_q, vb_nxt;
    logic          latch, latch_nxt;
    logic          ovr_nxt;
    logic [DW-1:0] xcnt, xcnt_nxt;
    logic [DW-1:0] dot;
    logic          end_of_line, end_of_frame;
    logic          start, running, done;

    // first enabled cycle after LCD off restarts at line 0 OAM
    assign start   = lcd_en && !en_q;
    assign running = lcd_en && en_q;
    // renderComplete seen this cycle counts as latched
    assign done    = latch || renderComplete;

    lcd_dot_counter #(
        .DOTS_PER_LINE  (DOTS_PER_LINE),
        .LINES_PER_FRAME(LINES_PER_FRAME),
        .DW             (DW)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr         (!running),
        .dot         (dot),
        .ly          (ly),
        .end_of_line (end_of_line),
        .end_of_frame(end_of_frame)
    );

    assign mode       = state;
    // pulses drop the instant the LCD is switched off
    assign drawline   = dl_q && lcd_en;
    assign vblank_irq = vb_q && lcd_en;

    // state and handshake registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= HBLANK;
            en_q    <= 1'b0;
            dl_q    <= 1'b0;
            vb_q    <= 1'b0;
            latch   <= 1'b0;
            xcnt    <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            en_q    <= lcd_en;
            dl_q    <= dl_nxt;
            vb_q    <= vb_nxt;
            latch   <= latch_nxt;
            xcnt    <= xcnt_nxt;
            overrun <= ovr_nxt;
        end
    end

    // mode sequencing; line end has priority so a late renderer is cut off
    always_comb begin
        state_nxt = state;
        dl_nxt    = 1'b0;
        vb_nxt    = 1'b0;
        latch_nxt = latch;
        xcnt_nxt  = xcnt;
        ovr_nxt   = overrun;
        if (!lcd_en) begin
            state_nxt = HBLANK;
            latch_nxt = 1'b0;
        end else if (start) begin
            state_nxt = OAM;
            latch_nxt = 1'b0;
            ovr_nxt   = 1'b0;
        end else if (end_of_line) begin
            if (state == XFER) begin
                ovr_nxt   = 1'b1;
                latch_nxt = 1'b0;
            end
            if (end_of_frame || ((ly + 8'd1) < VIS))
                state_nxt = OAM;
            else
                state_nxt = VBLANK;
            vb_nxt = (ly == VIS_LAST);
        end else begin
            case (state)
                OAM: begin
                    if (dot == OAM_LAST) begin
                        state_nxt = XFER;
                        dl_nxt    = 1'b1;
                        latch_nxt = 1'b0;
                        xcnt_nxt  = '0;
                    end
                end
                XFER: begin
                    latch_nxt = done;
                    if (done && (xcnt >= XMIN_M1))
                        state_nxt = HBLANK;
                    else
                        xcnt_nxt = xcnt + DW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef LCD_TIMING_LYC_COMPARE_EN
    logic [7:0] ly_nxt;
    logic       coin_nxt;

    // compare against the value ly takes next, so coincidence tracks ly exactly
    always_comb begin
        ly_nxt = 8'd0;
        if (running)
            ly_nxt = end_of_line ? (end_of_frame ? 8'd0 : ly + 8'd1) : ly;
        coin_nxt = (ly_nxt == lyc);
    end

    // registered coincidence and its rising-edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coincidence <= 1'b0;
            stat_irq    <= 1'b0;
        end else begin
            coincidence <= coin_nxt;
            stat_irq    <= coin_nxt && !coincidence;
        end
    end
`else
    logic unused_lyc;
    assign unused_lyc  = ^lyc;
    assign coincidence = 1'b0;
    assign stat_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_timing.sv
// Self-checking bench for lcd_timing: randomized renderer behaviour per line
// against a dot/line arithmetic reference model, plus directed timing points.
module tb_lcd_timing;

    localparam int D  = 456;
    localparam int L  = 154;
    localparam int V  = 144;
    localparam int O  = 80;
    localparam int XM = 172;
    localparam int FRAME = D * L;
    localparam int MAIN_CYC = FRAME + 50 * D + 100;

    logic       clk = 1'b0;
    logic       rst, lcd_en, renderComplete;
    logic [7:0] lyc;
    logic       drawline, vblank_irq, overrun, coincidence, stat_irq;
    logic [7:0] ly;
    logic [1:0] mode;

    lcd_timing dut (
        .clk           (clk),
        .rst           (rst),
        .lcd_en        (lcd_en),
        .renderComplete(renderComplete),
        .lyc           (lyc),
        .drawline      (drawline),
        .ly            (ly),
        .mode          (mode),
        .vblank_irq    (vblank_irq),
        .overrun       (overrun),
        .coincidence   (coincidence),
        .stat_irq      (stat_irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // reference model: cycles since enable, plus first renderer-done dot of the line
    bit m_run, m_ovr, m_coin, m_stat;
    int m_t, m_frc;

    function automatic int m_dot();
        return m_run ? (m_t % D) : 0;
    endfunction

    function automatic int m_ly();
        return m_run ? ((m_t / D) % L) : 0;
    endfunction

    function automatic int m_mode();
        int d, l, hb;
        if (!m_run) return 0;
        d = m_dot();
        l = m_ly();
        if (l >= V) return 1;
        if (d < O) return 2;
        hb = (m_frc > O + XM - 1) ? m_frc : O + XM - 1;
        if (m_frc >= 0 && d > hb) return 0;
        return 3;
    endfunction

    task automatic m_reset();
        m_run = 0; m_ovr = 0; m_coin = 0; m_stat = 0; m_t = 0; m_frc = -1;
    endtask

    task automatic m_step(input bit en, input bit rc, input int lycv);
        int d;
        if (!en) m_run = 0;
        else if (!m_run) begin
            m_run = 1; m_t = 0; m_ovr = 0; m_frc = -1;
        end else begin
            d = m_dot();
            if (m_ly() < V && d >= O) begin
                if (d == D - 1 && m_mode() == 3) m_ovr = 1;
                if (rc && m_frc < 0) m_frc = d;
            end
            m_t++;
            if (m_dot() == 0) m_frc = -1;
        end
`ifdef LCD_TIMING_LYC_COMPARE_EN
        m_stat = (m_ly() == lycv) && !m_coin;
        m_coin = (m_ly() == lycv);
`endif
    endtask

    task automatic check_all();
        chk("ly", int'(ly), m_ly());
        chk("mode", int'(mode), m_mode());
        chk("drawline", int'(drawline), int'(m_run && m_dot() == O && m_ly() < V));
        chk("vblank_irq", int'(vblank_irq), int'(m_run && m_dot() == 0 && m_ly() == V));
        chk("overrun", int'(overrun), int'(m_ovr));
        chk("coincidence", int'(coincidence), int'(m_coin));
        chk("stat_irq", int'(stat_irq), int'(m_stat));
    endtask

    // drive one edge's inputs, advance model, sample on the following negedge
    task automatic cyc(input bit en, input bit rc, input int lycv);
        lcd_en = en; renderComplete = rc; lyc = 8'(lycv);
        m_step(en, rc, lycv);
        @(negedge clk);
        check_all();
    endtask

    // renderer styles: 0 held high, 1 pulse 10 after drawline, 2 never, 3 random
    function automatic bit rc_of(input int sty, input int d);
        case (sty)
            0: return 1'b1;
            1: return d == O + 10;
            2: return 1'b0;
            default: return $urandom_range(0, 7) == 0;
        endcase
    endfunction

    int sty, xc, dl_cnt, lycr;

    initial begin
        rst = 1'b1; lcd_en = 1'b0; renderComplete = 1'b0; lyc = 8'd5;
        m_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        repeat (3) cyc(0, 1, 5);
        cyc(1, 0, 5);
        chk("start_oam", int'(mode), 2);

        sty = 1; xc = 0; dl_cnt = 0;
        for (int i = 0; i < MAIN_CYC; i++) begin
            if (m_dot() == 0) begin
                sty = (m_t == 0) ? 1 : int'($urandom_range(0, 3));
                xc = 0;
            end
            cyc(1, rc_of(sty, m_dot()), 5);
            if (mode == 2'd3) xc++;
            if (m_t < FRAME && drawline) dl_cnt++;
            if (m_dot() == D - 1 && m_ly() < V && sty == 0) chk("xfer_len", xc, XM);
            case (m_t)
                79:  chk("oam_dot79", int'(mode), 2);
                80:  chk("dl_dot80", int'(drawline), 1);
                251: chk("xfer_dot251", int'(mode), 3);
                252: chk("hb_dot252", int'(mode), 0);
                455: chk("ly_dot455", int'(ly), 0);
                456: chk("ly1_at456", int'(ly), 1);
                V * D - 1: chk("ly143", int'(ly), V - 1);
                V * D: begin
                    chk("vb_ly", int'(ly), V);
                    chk("vb_mode", int'(mode), 1);
                    chk("vb_irq", int'(vblank_irq), 1);
                end
                V * D + 1: chk("vb_irq_once", int'(vblank_irq), 0);
`ifdef LCD_TIMING_LYC_COMPARE_EN
                5 * D: begin
                    chk("stat_ly5", int'(stat_irq), 1);
                    chk("coin_ly5", int'(coincidence), 1);
                end
                5 * D + 1: chk("stat_once", int'(stat_irq), 0);
                6 * D - 1: chk("coin_end", int'(coincidence), 1);
                6 * D: chk("coin_off", int'(coincidence), 0);
`endif
                FRAME: begin
                    chk("frame_dl", dl_cnt, V);
                    chk("wrap_ly", int'(ly), 0);
                    chk("wrap_mode", int'(mode), 2);
                end
                default: ;
            endcase
        end
        chk("l50_ly", int'(ly), 50);
        chk("l50_xfer", int'(mode), 3);

        // asynchronous reset mid-XFER of line 50
        #2 rst = 1'b1;
        #1;
        m_reset();
        chk("arst_ly", int'(ly), 0);
        chk("arst_mode", int'(mode), 0);
        chk("arst_ovr", int'(overrun), 0);
        check_all();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        cyc(1, 0, 5);
        chk("rel_oam", int'(mode), 2);
        chk("rel_ly", int'(ly), 0);

        // renderer never finishes: overrun after line 0, then abort and re-enable
        for (int i = 0; i < D - 1; i++) cyc(1, 0, 5);
        chk("ovr_pre", int'(overrun), 0);
        cyc(1, 0, 5);
        chk("ovr_set", int'(overrun), 1);
        chk("ovr_ly1", int'(ly), 1);
        chk("ovr_oam", int'(mode), 2);
        for (int i = 0; i < 120; i++) cyc(1, 0, 5);
        chk("abort_pre", int'(mode), 3);
        cyc(0, 1, 5);
        chk("abort_mode", int'(mode), 0);
        chk("abort_ovr_hold", int'(overrun), 1);
        repeat (4) cyc(0, 1, 5);
        cyc(1, 0, 5);
        chk("ovr_clr", int'(overrun), 0);
        chk("reen_oam", int'(mode), 2);

        // random tail: sporadic LCD drops, random renderer, small lyc
        lycr = 0;
        for (int i = 0; i < 1200; i++) begin
            if (i % 300 == 0) lycr = int'($urandom_range(0, 1));
            cyc($urandom_range(0, 399) != 0, $urandom_range(0, 39) == 0, lycr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
